// File: rtl/bin2gray_counter.sv
// bin2gray_counter
//   Registered up/down counter that keeps its state in binary and publishes
//   it as Gray code. The Gray output is computed from the binary next-state
//   value and registered alongside it. Because g is never derived
//   combinationally from the binary outputs, it cannot glitch, and each step
//   changes exactly one of its bits.
//
//   Edge priority: rst > load > en.
//   tc pulses for one cycle after a step attempted from the terminal value:
//   MAX when counting up, 0 when counting down.
//   WRAP=1 makes the counter roll over at the terminal value.
//   WRAP=0 makes it saturate there, and tc then stays high on every
//   attempted step.
module bin2gray_counter #(
   parameter int WIDTH = 4,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_bin,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] b,
   output logic             tc
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH-1:0] MIN_VAL = '0;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] b_next;
   logic [WIDTH-1:0] g_next;
   logic             tc_next;
   logic             at_top;
   logic             at_bottom;

   assign at_top    = (b == MAX_VAL);
   assign at_bottom = (b == MIN_VAL);

   // Next binary value and terminal flag from load/step request (rst handled in the register)
   always_comb begin
      b_next  = b;
      tc_next = 1'b0;
      if (load) begin
         b_next = load_bin;
      end else if (en) begin
         if (up) begin
            if (at_top) begin
               tc_next = 1'b1;
               b_next  = WRAP ? MIN_VAL : MAX_VAL;
            end else begin
               b_next = b + ONE;
            end
         end else begin
            if (at_bottom) begin
               tc_next = 1'b1;
               b_next  = WRAP ? MAX_VAL : MIN_VAL;
            end else begin
               b_next = b - ONE;
            end
         end
      end
   end

   // Gray encoding taken from the same next-state value that feeds b
   always_comb begin
      g_next = b_next ^ (b_next >> 1);
   end

   // State registers; synchronous reset clears everything regardless of other inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         b  <= '0;
         g  <= '0;
         tc <= 1'b0;
      end else begin
         b  <= b_next;
         g  <= g_next;
         tc <= tc_next;
      end
   end

endmodule

// File: tb/tb_bin2gray_counter.sv
// Testbench for bin2gray_counter.
//   Vector table applied to a WIDTH=4 wrapping instance.
//   Hand-written saturation sequence for a WIDTH=4, WRAP=0 instance.
//   Randomized run against an arithmetic reference model on WIDTH=6 instances.
module tb_bin2gray_counter;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=4, WRAP=1
   logic       r4, en4, up4, ld4;
   logic [3:0] lb4, g4, b4;
   logic       tc4;
   // WIDTH=4, WRAP=0
   logic       r4s, en4s, up4s, ld4s;
   logic [3:0] lb4s, g4s, b4s;
   logic       tc4s;
   // WIDTH=6, WRAP=1 and WRAP=0 share random stimulus
   logic       r6, en6, up6, ld6;
   logic [5:0] lb6, g6w, b6w, g6s, b6s;
   logic       tc6w, tc6s;

   bin2gray_counter #(.WIDTH(4), .WRAP(1'b1)) dut4 (
      .clk(clk), .rst(r4), .en(en4), .up(up4), .load(ld4), .load_bin(lb4),
      .g(g4), .b(b4), .tc(tc4));
   bin2gray_counter #(.WIDTH(4), .WRAP(1'b0)) dut4s (
      .clk(clk), .rst(r4s), .en(en4s), .up(up4s), .load(ld4s), .load_bin(lb4s),
      .g(g4s), .b(b4s), .tc(tc4s));
   bin2gray_counter #(.WIDTH(6), .WRAP(1'b1)) dut6w (
      .clk(clk), .rst(r6), .en(en6), .up(up6), .load(ld6), .load_bin(lb6),
      .g(g6w), .b(b6w), .tc(tc6w));
   bin2gray_counter #(.WIDTH(6), .WRAP(1'b0)) dut6s (
      .clk(clk), .rst(r6), .en(en6), .up(up6), .load(ld6), .load_bin(lb6),
      .g(g6s), .b(b6s), .tc(tc6s));

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act);
      logic [31:0] exp_v;
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst, en, up, load;
      logic [3:0] lb;
      logic [3:0] eb, eg;
      logic       etc;
   } vec_t;

   vec_t vecs[64];
   int   n_vecs = 0;
   logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                             4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                             4'b1010, 4'b1011, 4'b1001, 4'b1000};

   task automatic add(input logic rst, en, up, load, input logic [3:0] lb,
                      input logic [3:0] eb, eg, input logic etc);
      vecs[n_vecs].rst = rst;  vecs[n_vecs].en = en;
      vecs[n_vecs].up = up;    vecs[n_vecs].load = load;
      vecs[n_vecs].lb = lb;    vecs[n_vecs].eb = eb;
      vecs[n_vecs].eg = eg;    vecs[n_vecs].etc = etc;
      n_vecs++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive4s(input logic rst, en, up, load, input logic [3:0] lb);
      r4s = rst; en4s = en; up4s = up; ld4s = load; lb4s = lb;
      @(posedge clk); #1;
   endtask

   task automatic check4s(input string name, input logic [3:0] eb, eg, input logic etc);
      exp_q.push_back(32'(eb));  chk({name, ".b"}, 32'(b4s));
      exp_q.push_back(32'(eg));  chk({name, ".g"}, 32'(g4s));
      exp_q.push_back(32'(etc)); chk({name, ".tc"}, 32'(tc4s));
   endtask

   // Reference model: plain integer arithmetic on the counter value
   task automatic model_step(input int m, input bit wrap, input logic rst, en, up, load,
                             input int lb, output int nm, output int ntc);
      int maxv;
      maxv = 63;
      nm  = m;
      ntc = 0;
      if (rst) nm = 0;
      else if (load) nm = lb;
      else if (en) begin
         if (up) begin
            ntc = (m + 1 > maxv) ? 1 : 0;
            nm  = wrap ? (m + 1) % (maxv + 1) : ((m + 1 > maxv) ? maxv : m + 1);
         end else begin
            ntc = (m - 1 < 0) ? 1 : 0;
            nm  = wrap ? (m + maxv) % (maxv + 1) : ((m - 1 < 0) ? 0 : m - 1);
         end
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [3:0] prev_g;
      logic [3:0] prev_b;
      int mw, ms, tcw, tcs, nmw, nms;
      logic [5:0] pgw, pbw, pgs, pbs;

      r4 = 1'b1; en4 = 0; up4 = 0; ld4 = 0; lb4 = 0;
      r4s = 1'b1; en4s = 0; up4s = 0; ld4s = 0; lb4s = 0;
      r6 = 1'b1; en6 = 0; up6 = 0; ld6 = 0; lb6 = 0;
      @(posedge clk); #1;

      // Reset wins over load and en
      add(1, 1, 1, 1, 4'hF, 4'd0, 4'b0000, 0);
      // Count up through the full Gray sequence
      for (int i = 1; i < 16; i++) add(0, 1, 1, 0, 4'h0, 4'(i), gseq[i], 0);
      // Wrap MAX -> 0 with tc pulse
      add(0, 1, 1, 0, 4'h0, 4'd0, 4'b0000, 1);
      // Down from 0 wraps to MAX with tc, then continues down
      add(0, 1, 0, 0, 4'h0, 4'd15, 4'b1000, 1);
      add(0, 0, 0, 0, 4'h0, 4'd15, 4'b1000, 0);
      add(0, 1, 0, 0, 4'h0, 4'd14, 4'b1001, 0);
      // Load wins over en on the same edge
      add(0, 1, 1, 1, 4'd9, 4'd9, 4'b1101, 0);
      add(0, 1, 1, 0, 4'h0, 4'd10, 4'b1111, 0);
      // Hold keeps value
      add(0, 0, 1, 0, 4'h3, 4'd10, 4'b1111, 0);
      // Mid-count reset, then counting resumes from 0
      add(1, 1, 1, 0, 4'h0, 4'd0, 4'b0000, 0);
      add(0, 1, 1, 0, 4'h0, 4'd1, 4'b0001, 0);
      // Direction change each cycle
      add(0, 1, 0, 0, 4'h0, 4'd0, 4'b0000, 0);
      add(0, 1, 1, 0, 4'h0, 4'd1, 4'b0001, 0);

      prev_g = g4;
      prev_b = b4;
      for (int i = 0; i < n_vecs; i++) begin
         r4 = vecs[i].rst; en4 = vecs[i].en; up4 = vecs[i].up;
         ld4 = vecs[i].load; lb4 = vecs[i].lb;
         @(posedge clk); #1;
         exp_q.push_back(32'(vecs[i].eb));  chk($sformatf("vec%0d.b", i), 32'(b4));
         exp_q.push_back(32'(vecs[i].eg));  chk($sformatf("vec%0d.g", i), 32'(g4));
         exp_q.push_back(32'(vecs[i].etc)); chk($sformatf("vec%0d.tc", i), 32'(tc4));
         if (!vecs[i].rst && !vecs[i].load && vecs[i].en && vecs[i].eb != prev_b) begin
            exp_q.push_back(32'd1);
            chk($sformatf("vec%0d.onebit", i), 32'($countones(g4 ^ prev_g)));
         end
         prev_g = g4;
         prev_b = b4;
      end
      r4 = 1'b0; en4 = 1'b0; ld4 = 1'b0;

      // Saturating instance
      drive4s(1, 0, 0, 0, 4'h0);     check4s("sat_rst", 4'd0, 4'b0000, 0);
      drive4s(0, 0, 0, 1, 4'd14);    check4s("sat_ld14", 4'd14, 4'b1001, 0);
      drive4s(0, 1, 1, 0, 4'h0);     check4s("sat_up1", 4'd15, 4'b1000, 0);
      drive4s(0, 1, 1, 0, 4'h0);     check4s("sat_up2", 4'd15, 4'b1000, 1);
      drive4s(0, 1, 1, 0, 4'h0);     check4s("sat_up3", 4'd15, 4'b1000, 1);
      drive4s(0, 1, 1, 0, 4'h0);     check4s("sat_up4", 4'd15, 4'b1000, 1);
      drive4s(0, 1, 0, 0, 4'h0);     check4s("sat_dn", 4'd14, 4'b1001, 0);
      drive4s(0, 0, 0, 1, 4'd0);     check4s("sat_ld0", 4'd0, 4'b0000, 0);
      drive4s(0, 1, 0, 0, 4'h0);     check4s("sat_bot1", 4'd0, 4'b0000, 1);
      drive4s(0, 1, 0, 0, 4'h0);     check4s("sat_bot2", 4'd0, 4'b0000, 1);
      drive4s(0, 0, 0, 0, 4'h0);     check4s("sat_hold", 4'd0, 4'b0000, 0);

      // Randomized run on WIDTH=6 against the reference model
      r6 = 1'b1; en6 = 0; ld6 = 0;
      @(posedge clk); #1;
      mw = 0; ms = 0;
      pgw = g6w; pbw = b6w; pgs = g6s; pbs = b6s;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         r6  = ($urandom_range(0, 99) < 2);
         ld6 = ($urandom_range(0, 99) < 8);
         en6 = ($urandom_range(0, 3) != 0);
         up6 = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: lb6 = 6'd63;
            1: lb6 = 6'd0;
            default: lb6 = 6'($urandom_range(0, 63));
         endcase
         model_step(mw, 1'b1, r6, en6, up6, ld6, int'(lb6), nmw, tcw);
         model_step(ms, 1'b0, r6, en6, up6, ld6, int'(lb6), nms, tcs);
         @(posedge clk); #1;
         exp_q.push_back(32'(nmw));             chk("rnd_wrap.b", 32'(b6w));
         exp_q.push_back(32'(nmw ^ (nmw >> 1))); chk("rnd_wrap.g", 32'(g6w));
         exp_q.push_back(32'(tcw));             chk("rnd_wrap.tc", 32'(tc6w));
         exp_q.push_back(32'(b6w ^ (b6w >> 1))); chk("rnd_wrap.inv", 32'(g6w));
         exp_q.push_back(32'(nms));             chk("rnd_sat.b", 32'(b6s));
         exp_q.push_back(32'(nms ^ (nms >> 1))); chk("rnd_sat.g", 32'(g6s));
         exp_q.push_back(32'(tcs));             chk("rnd_sat.tc", 32'(tc6s));
         exp_q.push_back(32'(b6s ^ (b6s >> 1))); chk("rnd_sat.inv", 32'(g6s));
         if (!r6 && !ld6 && nmw != mw) begin
            exp_q.push_back(32'd1); chk("rnd_wrap.onebit", 32'($countones(g6w ^ pgw)));
         end
         if (!r6 && !ld6 && nms != ms) begin
            exp_q.push_back(32'd1); chk("rnd_sat.onebit", 32'($countones(g6s ^ pgs)));
         end
         mw = nmw; ms = nms;
         pgw = g6w; pbw = b6w; pgs = g6s; pbs = b6s;
      end

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
